// File: rtl/vec_mem_responder.sv
// Byte-addressed memory responder servicing scalar (1 byte) and vector (VLEN byte) loads/stores.
// Define VMEM_WIDE_ACCESS_EN to move vector accesses 4 bytes per cycle instead of 1.
module vec_mem_responder #(
  parameter int DEPTH = 1024,
  parameter int VLEN  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              op_type,
  input  logic              write_enable,
  input  logic [15:0]       address,
  input  logic [VLEN*8-1:0] wdata_v,
  input  logic [7:0]        wdata_s,
  output logic [VLEN*8-1:0] rdata_v,
  output logic [7:0]        rdata_s,
  output logic              mem_finished,
  output logic [7:0]        mem_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(VLEN + 1);
`ifdef VMEM_WIDE_ACCESS_EN
  localparam int LANES = 4;
`else
  localparam int LANES = 1;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VLEN*8-1:0] rdv_q, rdv_d;
  logic [7:0]        rds_q, rds_d;
  logic [7:0]        md_q, md_d;
  logic              fin_q, fin_d;

  logic [15:0]       addr_q;
  logic              vec_q;
  logic              we_q;
  logic [VLEN*8-1:0] wdv_q;
  logic [7:0]        wds_q;

  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     idx [LANES];
  logic [7:0]        wbyte [LANES];
  logic [LANES-1:0]  lane_en;
  logic              last;

  // Per-lane byte address (wraps at the RAM end) and store byte for the current element group.
  always_comb begin
    lane_en = '0;
    for (int j = 0; j < LANES; j++) begin
      idx[j]     = AW'(addr_q + 16'(cnt_q) + 16'(j));
      lane_en[j] = vec_q ? ((int'(cnt_q) + j) < VLEN) : (j == 0);
      wbyte[j]   = vec_q ? wdv_q[(int'(cnt_q) + j)*8 +: 8] : wds_q;
    end
    last = vec_q ? ((int'(cnt_q) + LANES) >= VLEN) : 1'b1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdv_d   = rdv_q;
    rds_d   = rds_q;
    md_d    = md_q;
    fin_d   = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        // Later lanes override mem_data so it shows the highest-index byte of the group.
        for (int j = 0; j < LANES; j++) begin
          if (lane_en[j]) begin
            if (we_q) begin
              md_d = wbyte[j];
            end else begin
              md_d = mem[idx[j]];
              if (vec_q) rdv_d[(int'(cnt_q) + j)*8 +: 8] = mem[idx[j]];
              else       rds_d = mem[idx[j]];
            end
          end
        end
        cnt_d = cnt_q + CW'(LANES);
        if (last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdv_q   <= '0;
      rds_q   <= '0;
      md_q    <= '0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdv_q   <= rdv_d;
      rds_q   <= rds_d;
      md_q    <= md_d;
      fin_q   <= fin_d;
    end
  end

  // Request fields are only sampled in the accept cycle; they need no reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && req_valid) begin
      addr_q <= address;
      vec_q  <= op_type;
      we_q   <= write_enable;
      wdv_q  <= wdata_v;
      wds_q  <= wdata_s;
    end
  end

  // RAM is never reset; an async reset drops state to IDLE so no further bytes are written.
  always_ff @(posedge clk) begin
    if (state_q == ACCESS && we_q) begin
      for (int j = 0; j < LANES; j++) begin
        if (lane_en[j]) mem[idx[j]] <= wbyte[j];
      end
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign rdata_v      = rdv_q;
  assign rdata_s      = rds_q;
  assign mem_data     = md_q;
  assign mem_finished = fin_q;

endmodule

// File: tb/tb_vec_mem_responder.sv
// Randomized and directed bench for vec_mem_responder against a transaction-level memory model.
module tb_vec_mem_responder;

  localparam int DEPTH = 1024;
  localparam int VLEN  = 20;
`ifdef VMEM_WIDE_ACCESS_EN
  localparam int NV      = 5;
  localparam int LANES   = 4;
  localparam int ABORT_K = 2;
`else
  localparam int NV      = 20;
  localparam int LANES   = 1;
  localparam int ABORT_K = 10;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              op_type;
  logic              write_enable;
  logic [15:0]       address;
  logic [VLEN*8-1:0] wdata_v;
  logic [7:0]        wdata_s;
  logic [VLEN*8-1:0] rdata_v;
  logic [7:0]        rdata_s;
  logic              mem_finished;
  logic [7:0]        mem_data;

  vec_mem_responder #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .op_type(op_type), .write_enable(write_enable), .address(address),
    .wdata_v(wdata_v), .wdata_s(wdata_s), .rdata_v(rdata_v), .rdata_s(rdata_s),
    .mem_finished(mem_finished), .mem_data(mem_data)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;
  int busy_lo = -1;
  int busy_hi = -1;
  int fin_edge = -1;
  int free_edge = 0;
  bit started = 1'b0;

  logic [7:0]        mem_m [DEPTH];
  logic [VLEN*8-1:0] rdv_m = '0;
  logic [7:0]        rds_m = '0;
  logic [7:0]        md_m = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [VLEN*8-1:0] act, input logic [VLEN*8-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Every cycle: handshake/completion timing from the model, data whenever no access is in flight.
  always @(negedge clk) begin
    bit busy;
    if (started) begin
      busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("req_ready", req_ready, !busy);
      chk("mem_finished", mem_finished, cyc == fin_edge);
      if (!busy) begin
        chk("rdata_v", rdata_v, rdv_m);
        chk("rdata_s", rdata_s, rds_m);
        chk("mem_data", mem_data, md_m);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_txn(input logic op, input logic we, input logic [15:0] ad,
                        input logic [VLEN*8-1:0] wv, input logic [7:0] ws,
                        input bit hold, input int abort_k);
    int a_edge, n, nb, ma;
    logic [7:0] b;
    op_type = op; write_enable = we; address = ad; wdata_v = wv; wdata_s = ws;
    req_valid = 1'b1;
    a_edge = (cyc + 1 > free_edge) ? cyc + 1 : free_edge;
    while (cyc < a_edge) step();
    if (!hold) begin
      req_valid = 1'b0;
      op_type = 1'($urandom); write_enable = 1'($urandom);
      address = 16'($urandom); wdata_s = 8'($urandom);
    end
    n  = op ? NV : 1;
    nb = op ? VLEN : 1;
    if (abort_k > 0 && abort_k * LANES < nb) nb = abort_k * LANES;
    for (int i = 0; i < nb; i++) begin
      ma = (int'(ad) + i) % DEPTH;
      b  = op ? wv[i*8 +: 8] : ws;
      if (we) begin
        mem_m[ma] = b;
        md_m = b;
      end else begin
        if (op) rdv_m[i*8 +: 8] = mem_m[ma];
        else    rds_m = mem_m[ma];
        md_m = mem_m[ma];
      end
    end
    busy_lo = a_edge; busy_hi = a_edge + n;
    fin_edge = a_edge + n + 1; free_edge = a_edge + n + 2;
    if (abort_k > 0) begin
      while (cyc < a_edge + abort_k) step();
      rst = 1'b0;
      rdv_m = '0; rds_m = '0; md_m = '0;
      busy_hi = -1; fin_edge = -1;
      repeat (2) step();
      rst = 1'b1;
      free_edge = cyc + 1;
    end
  endtask

  task automatic wait_done();
    while (cyc < fin_edge) step();
  endtask

  function automatic logic [VLEN*8-1:0] ramp(input int base);
    logic [VLEN*8-1:0] v;
    for (int i = 0; i < VLEN; i++) v[i*8 +: 8] = 8'(base + i);
    return v;
  endfunction

  function automatic logic [VLEN*8-1:0] rand_vec();
    logic [VLEN*8-1:0] v;
    for (int i = 0; i < VLEN; i++) v[i*8 +: 8] = 8'($urandom);
    return v;
  endfunction

  initial begin
    rst = 1'b0; req_valid = 1'b0; op_type = 1'b0; write_enable = 1'b0;
    address = '0; wdata_v = '0; wdata_s = '0;
    step();
    started = 1'b1;
    chk("reset_ready", req_ready, 1);
    chk("reset_finished", mem_finished, 0);
    chk("reset_rdata_v", rdata_v, 0);
    chk("reset_rdata_s", rdata_s, 0);
    chk("reset_mem_data", mem_data, 0);
    step();
    rst = 1'b1;
    free_edge = cyc + 1;

    // Fill the whole RAM so every model byte is known.
    for (int a = 0; a < DEPTH; a += VLEN) do_txn(1'b1, 1'b1, 16'(a), rand_vec(), 8'h00, 1'b0, 0);
    wait_done();

    // Vector store/load at 0.
    do_txn(1'b1, 1'b1, 16'h0000, ramp(100), 8'h00, 1'b0, 0);
    wait_done();
    chk("vstore_fin_pulse", mem_finished, 1);
    do_txn(1'b1, 1'b0, 16'h0000, '0, 8'h00, 1'b0, 0);
    wait_done();
    chk("vload_ramp100", rdata_v, ramp(100));

    // Scalar store/load at 0x10; rdata_v untouched.
    do_txn(1'b0, 1'b1, 16'h0010, '0, 8'h5A, 1'b0, 0);
    do_txn(1'b0, 1'b0, 16'h0010, '0, 8'h00, 1'b0, 0);
    wait_done();
    chk("sload_5a", rdata_s, 8'h5A);
    chk("sload_fin_pulse", mem_finished, 1);
    chk("rdata_v_kept", rdata_v, ramp(100));

    // Wrapping vector store.
    do_txn(1'b1, 1'b1, 16'(DEPTH - 5), ramp(50), 8'h00, 1'b0, 0);
    do_txn(1'b0, 1'b0, 16'h0000, '0, 8'h00, 1'b0, 0);
    wait_done();
    chk("wrap_addr0", rdata_s, 8'd55);
    do_txn(1'b0, 1'b0, 16'h000E, '0, 8'h00, 1'b0, 0);
    wait_done();
    chk("wrap_addr0e", rdata_s, 8'd69);

    // Reset in the middle of a vector store.
    do_txn(1'b1, 1'b1, 16'h0100, ramp(100), 8'h00, 1'b0, ABORT_K);
    chk("abort_ready", req_ready, 1);
    chk("abort_finished", mem_finished, 0);
    chk("abort_rdata_v", rdata_v, 0);
    chk("abort_mem_data", mem_data, 0);
    for (int i = 0; i < ABORT_K * LANES; i++) begin
      do_txn(1'b0, 1'b0, 16'(16'h0100 + i), '0, 8'h00, 1'b0, 0);
      wait_done();
      chk("abort_written", rdata_s, 8'(100 + i));
    end
    for (int i = ABORT_K * LANES; i < VLEN; i++) do_txn(1'b0, 1'b0, 16'(16'h0100 + i), '0, 8'h00, 1'b0, 0);
    wait_done();

    // Back-to-back scalar loads with req_valid held high.
    for (int i = 0; i < 4; i++) do_txn(1'b0, 1'b0, 16'h0010, '0, 8'h00, (i < 3), 0);
    wait_done();
    chk("b2b_rdata_s", rdata_s, 8'h5A);

    // Random traffic.
    for (int t = 0; t < 250; t++) begin
      repeat ($urandom_range(2, 0)) step();
      do_txn(1'($urandom), 1'($urandom), 16'($urandom), rand_vec(), 8'($urandom), 1'b0, 0);
    end
    wait_done();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vec_mem_responder.md
VEC_MEM_RESPONDER -- requirements
Module: vec_mem_responder

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 1024, data RAM size in bytes (power of two, 32..65536).
REQ-002 The block SHALL have one parameter: VLEN, default 20, bytes per vector access (fixed to 20 for this release).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  high exactly when in IDLE.
REQ-007 op_type  input  1  0 = scalar (1 byte), 1 = vector (VLEN bytes).
REQ-008 write_enable  input  1  1 = store, 0 = load.
REQ-009 address  input  16  byte address of element 0.
REQ-010 wdata_v  input  20x8  vector store data; element i goes to address+i.
REQ-011 wdata_s  input  8  scalar store data.
REQ-012 rdata_v  output  20x8  vector load result.
REQ-013 rdata_s  output  8  scalar load result.
REQ-014 mem_finished  output  1  one-cycle completion pulse.
REQ-015 mem_data  output  8  byte most recently read or written (debug).

Function
REQ-016 The block SHALL hold an internal byte RAM of DEPTH entries, indexed by (address + i) mod DEPTH, so that accesses wrap at the end of the RAM.
REQ-017 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-018 In IDLE, req_valid=1 SHALL capture address, op_type, write_enable, wdata_v and wdata_s, clear the element counter and move to ACCESS; inputs are ignored outside that capture cycle.
REQ-019 In ACCESS, the block SHALL process one byte per cycle at element index k: on a store, write the byte into the RAM; on a load, register the RAM byte into rdata_v[k] (vector) or rdata_s (scalar); in both cases mem_data takes the byte.
REQ-020 ACCESS SHALL last 1 cycle for a scalar access and VLEN cycles for a vector access, then move to DONE.
REQ-021 DONE SHALL assert mem_finished for exactly one cycle and return to IDLE; req_valid is not accepted in DONE.
REQ-022 Total latency from the accept edge to mem_finished SHALL be N+1 cycles: 2 for scalar, 21 for vector.
REQ-023 Within one vector store, every write SHALL complete before mem_finished; a following load of the same address returns the stored data.
REQ-024 rdata_v and rdata_s SHALL hold their values until the next load of the same type overwrites them; stores SHALL not alter them.
REQ-025 Vector elements that are not rewritten SHALL keep their previous values; a load fills all VLEN elements.

Reset
REQ-026 Asserting rst=0 SHALL immediately force IDLE with req_ready=1, mem_finished=0, rdata_v=0, rdata_s=0, mem_data=0 and counter=0.
REQ-027 A reset in the middle of an operation SHALL abort it without a mem_finished pulse; bytes already written stay written and the rest are not written.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 When the macro VMEM_WIDE_ACCESS_EN is defined, vector ACCESS SHALL process 4 consecutive bytes per cycle (5 cycles, latency 6), and mem_data SHALL show the highest-index byte of each group.
REQ-030 When VMEM_WIDE_ACCESS_EN is undefined, the block SHALL process one byte per cycle (REQ-019/020); scalar behaviour SHALL be identical in both builds.

Verification
REQ-031 Reset, then a vector store to address 0x0000 with wdata_v[i]=100+i -> mem_finished 21 cycles after accept; a vector load of 0x0000 returns rdata_v[i]=100+i.
REQ-032 Scalar store of 0x5A to 0x0010, then scalar load of 0x0010 -> rdata_s=0x5A, latency 2, and rdata_v is unchanged.
REQ-033 Vector store with wdata_v[i]=50+i to address DEPTH-5 (1019) -> bytes wrap: a scalar load of 0x0000 returns 55 and a load of 0x000E returns 69.
REQ-034 Pull rst=0 during cycle 10 of a vector store with wdata_v[i]=100+i to address 0x0100 -> no mem_finished, outputs 0; loads of addresses 0x0100..0x0109 return 100..109 and the remaining addresses are unchanged.
REQ-035 Hold req_valid=1 continuously for back-to-back scalar loads -> req_ready is low in ACCESS/DONE, and one request is accepted every 3 cycles.
REQ-036 Build with VMEM_WIDE_ACCESS_EN and repeat REQ-031 -> identical data, mem_finished 6 cycles after accept.
